// File: rtl/stream_burst_addr_gen_counter.sv
// Beat counter: clears to zero, increments by one when enabled.
// Latency: count visible the cycle after the enable edge.
// Backpressure: none; the caller gates en_i with its own handshake.
module stream_burst_addr_gen_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/stream_burst_addr_gen.sv
// Burst address generator: turns {base, stride, len, we} descriptors into beat requests.
// Latency: first beat is valid the cycle after descriptor acceptance; done pulses after the last beat.
// Backpressure: beats hold while req_ready_i is low; the next descriptor is taken on the last beat.
module stream_burst_addr_gen #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned LenWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic [AddrWidth-1:0] desc_addr_i,
  input  logic [AddrWidth-1:0] desc_stride_i,
  input  logic [LenWidth-1:0]  desc_len_i,
  input  logic                 desc_we_i,
  input  logic                 desc_valid_i,
  output logic                 desc_ready_o,
  output logic [AddrWidth-1:0] req_addr_o,
  output logic                 req_we_o,
  output logic                 req_last_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  logic [0:0]           state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [AddrWidth-1:0] stride_q;
  logic [LenWidth-1:0]  len_q;
  logic                 we_q;
  logic                 done_q;
  logic [LenWidth-1:0]  beat_cnt;

  logic beat_hs;
  logic last_hs;
  logic desc_hs;
  logic desc_empty;
  logic start;

  assign busy_o      = (state_q == StBurst);
  assign req_valid_o = busy_o;
  assign req_addr_o  = addr_q;
  assign req_we_o    = we_q;
  assign req_last_o  = busy_o && (beat_cnt == len_q - LenWidth'(1));
  assign done_o      = done_q;

  assign beat_hs      = req_valid_o && req_ready_i;
  assign last_hs      = beat_hs && req_last_o;
  assign desc_ready_o = (state_q == StIdle) || last_hs;
  assign desc_hs      = desc_valid_i && desc_ready_o;
  assign desc_empty   = (desc_len_i == '0);
  assign start        = desc_hs && !desc_empty && !clr_i;

  // The counter restarts on every new burst so k tracks the beat in flight.
  stream_burst_addr_gen_counter #(
    .Width (LenWidth)
  ) u_beat_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i || start),
    .en_i   (beat_hs && !last_hs),
    .cnt_o  (beat_cnt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
    end else if (clr_i) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      done_q <= last_hs || (desc_hs && desc_empty);
      if (start) begin
        state_q  <= StBurst;
        addr_q   <= desc_addr_i;
        stride_q <= desc_stride_i;
        len_q    <= desc_len_i;
        we_q     <= desc_we_i;
      end else if (last_hs) begin
        state_q <= StIdle;
      end else if (beat_hs) begin
        // Accumulated sum wraps naturally at the address width.
        addr_q <= addr_q + stride_q;
      end
    end
  end

endmodule

// File: tb/tb_stream_burst_addr_gen.sv
module tb_stream_burst_addr_gen;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clr_i = 1'b0;
  logic [31:0] desc_addr_i = '0;
  logic [31:0] desc_stride_i = '0;
  logic [15:0] desc_len_i = '0;
  logic        desc_we_i = 1'b0;
  logic        desc_valid_i = 1'b0;
  logic        desc_ready_o;
  logic [31:0] req_addr_o;
  logic        req_we_o;
  logic        req_last_o;
  logic        req_valid_o;
  logic        req_ready_i = 1'b1;
  logic        busy_o;
  logic        done_o;

  int n_chk = 0;
  int n_pass = 0;
  bit rdy_rand = 1'b0;

  stream_burst_addr_gen #(.AddrWidth(32), .LenWidth(16)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clr_i         (clr_i),
    .desc_addr_i   (desc_addr_i),
    .desc_stride_i (desc_stride_i),
    .desc_len_i    (desc_len_i),
    .desc_we_i     (desc_we_i),
    .desc_valid_i  (desc_valid_i),
    .desc_ready_o  (desc_ready_o),
    .req_addr_o    (req_addr_o),
    .req_we_o      (req_we_o),
    .req_last_o    (req_last_o),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  // Reference model: the active burst is a descriptor plus beat index k;
  // beat k lives at base + k*stride.
  bit          m_act = 1'b0;
  logic [31:0] m_base, m_stride;
  int          m_len, m_k;
  bit          m_we;
  bit          done_exp = 1'b0;

  always @(negedge clk_i) begin
    bit          el, hs, lasths, dready, dhs;
    logic [31:0] ea;
    if (!rst_ni) begin
      m_act    = 1'b0;
      done_exp = 1'b0;
    end else begin
      el = 1'b0;
      chk("valid", req_valid_o, m_act);
      chk("busy", busy_o, m_act);
      chk("done", done_o, done_exp);
      if (m_act) begin
        ea = m_base + m_stride * 32'(m_k);
        el = (m_k == m_len - 1);
        chk("addr", req_addr_o, ea);
        chk("we", req_we_o, m_we);
        chk("last", req_last_o, el);
      end
      hs     = m_act && req_ready_i;
      lasths = hs && el;
      dready = !m_act || lasths;
      chk("desc_ready", desc_ready_o, dready);
      dhs = desc_valid_i && dready;
      if (clr_i) begin
        m_act    = 1'b0;
        done_exp = 1'b0;
      end else begin
        done_exp = lasths || (dhs && desc_len_i == 16'd0);
        if (hs) begin
          m_k++;
          if (lasths) m_act = 1'b0;
        end
        if (dhs && desc_len_i != 16'd0) begin
          m_act    = 1'b1;
          m_base   = desc_addr_i;
          m_stride = desc_stride_i;
          m_len    = int'(desc_len_i);
          m_we     = desc_we_i;
          m_k      = 0;
        end
      end
    end
  end

  always @(posedge clk_i) begin
    #1 req_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(input logic [31:0] a, input logic [31:0] s, input logic [15:0] l, input bit w);
    bit got;
    int t;
    desc_addr_i   = a;
    desc_stride_i = s;
    desc_len_i    = l;
    desc_we_i     = w;
    desc_valid_i  = 1'b1;
    got = 1'b0;
    t   = 0;
    while (!got && t < 2000) begin
      @(negedge clk_i);
      got = desc_ready_o;
      @(posedge clk_i);
      #2;
      t++;
    end
    if (!got) chk("desc_timeout", 0, 1);
    desc_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((m_act || done_exp) && t < 5000) begin
      @(posedge clk_i);
      #2;
      t++;
    end
    if (t >= 5000) chk("idle_timeout", 0, 1);
    repeat (2) @(posedge clk_i);
    #2;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_valid", req_valid_o, 0);
    chk("rst_addr", req_addr_o, 0);
    chk("rst_we", req_we_o, 0);
    chk("rst_last", req_last_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #2;
    chk("rst_desc_ready", desc_ready_o, 1);

    send(32'h0000_1000, 32'd4, 16'd3, 1'b1);
    wait_idle();
    send(32'hFFFF_FFF8, 32'd8, 16'd3, 1'b0);
    wait_idle();
    send(32'h0000_4000, 32'd4, 16'd0, 1'b1);
    wait_idle();

    rdy_rand = 1'b1;
    repeat (3) begin
      send($urandom, $urandom, 16'd5, 1'($urandom_range(0, 1)));
      wait_idle();
    end
    rdy_rand = 1'b0;
    @(posedge clk_i);
    #2;

    send(32'h0000_8000, 32'h10, 16'd4, 1'b1);
    send(32'h0001_0000, 32'h20, 16'd3, 1'b0);
    wait_idle();

    send(32'h0000_2000, 32'h10, 16'd4, 1'b1);
    @(posedge clk_i);
    #2 clr_i = 1'b1;
    @(posedge clk_i);
    #2 clr_i = 1'b0;
    send(32'h0000_3000, 32'h4, 16'd2, 1'b0);
    wait_idle();

    send(32'h0000_5000, 32'h8, 16'd6, 1'b1);
    @(posedge clk_i);
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    chk("arst_valid", req_valid_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_last", req_last_o, 0);
    chk("arst_addr", req_addr_o, 0);
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #2;

    send(32'h0002_0000, 32'h4, 16'd300, 1'b1);
    wait_idle();

    for (int i = 0; i < 30; i++) begin
      rdy_rand = 1'($urandom_range(0, 1));
      send($urandom, 32'($urandom_range(0, 64)) << 2, 16'($urandom_range(0, 8)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    rdy_rand = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
